// File: rtl/up_down_key_cond.sv
// Key conditioner for the Up/Down game: sync, debounce and falling-edge strobe per button.
// Optional digit-key auto-repeat is enabled by defining KEY_AUTOREPEAT_EN.
module up_down_key_cond #(
  parameter int DEB_CYCLES    = 1000000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic i_Num0,
  input  logic i_Num1,
  input  logic i_Start,
  output logic o_fNum0,
  output logic o_fNum1,
  output logic o_fStart
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  if (DEB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_badParam
    $error("up_down_key_cond: DEB_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  logic [2:0] w_raw;
  logic [2:0] w_out;

  assign w_raw    = {i_Start, i_Num1, i_Num0};
  assign o_fNum0  = w_out[0];
  assign o_fNum1  = w_out[1];
  assign o_fStart = w_out[2];

  for (genvar g = 0; g < 3; g++) begin : g_chan
    logic          r_sync1;
    logic          r_sync2;
    logic          r_s;
    logic          r_out;
    logic [CW-1:0] r_cnt;
    logic          w_hit;
    logic          w_fall;
    logic          w_rep;

    // The level is accepted on the cycle the differing count would reach DEB_CYCLES.
    assign w_hit  = (r_sync2 != r_s) && (r_cnt == CW'(DEB_CYCLES - 1));
    assign w_fall = w_hit & r_s;
    assign w_out[g] = r_out;

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        r_sync1 <= 1'b1;
        r_sync2 <= 1'b1;
        r_s     <= 1'b1;
        r_cnt   <= '0;
        r_out   <= 1'b1;
      end else begin
        r_sync1 <= w_raw[g];
        r_sync2 <= r_sync1;
        if (r_sync2 == r_s) begin
          r_cnt <= '0;
        end else if (w_hit) begin
          r_s   <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        r_out <= ~(w_fall | w_rep);
      end
    end

`ifdef KEY_AUTOREPEAT_EN
    if (g < 2) begin : g_repeat
      localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int HW   = $clog2(RMAX + 1);

      logic [HW-1:0] r_hold;
      logic          r_rep;
      logic          w_rise;

      // No repeat strobe on the edge where the release itself is accepted.
      assign w_rise = w_hit & ~r_s;
      assign w_rep  = ~r_s & ~w_rise &
                      (r_hold == (r_rep ? HW'(REPEAT_PERIOD - 1) : HW'(REPEAT_DELAY - 1)));

      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          r_hold <= '0;
          r_rep  <= 1'b0;
        end else if (r_s) begin
          r_hold <= '0;
          r_rep  <= 1'b0;
        end else if (w_rep) begin
          r_hold <= '0;
          r_rep  <= 1'b1;
        end else begin
          r_hold <= r_hold + 1'b1;
        end
      end
    end else begin : g_noRepeat
      assign w_rep = 1'b0;
    end
`else
    assign w_rep = 1'b0;
`endif
  end

endmodule
